dma_requester: RTL and testbench
================================

// Module: dma_requester
// PURPOSE
//  Processor-side end of the DMA request interface: one instance per processor.
//  Accepts copy commands from the core, raises the toggle-trigger to the DMA, waits for the
//  DMA's ack toggle, returns the page pointer and grants the DMA the local memory port meanwhile.
//  Sits between the core, its local RAM and one DMA channel slot.
// PARAMETERS
//  SIZE       4    shared-memory address width (ptr)
//  PAGE_SIZE  2    log2 words per page; page index width = SIZE-PAGE_SIZE
//  PROCSIZE   4    local-memory address width
//  WORD_SIZE  16   data word width
//  TIMEOUT    255  max cycles in WAIT_ACK before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clock          in   1          system clock, all logic on posedge
//  reset_n        in   1          asynchronous, active-low reset
//  cmd_valid      in   1          core command request
//  cmd_ready      out  1          high in IDLE only; transfer on valid&ready
//  cmd_action     in   1          0=READ (shm->local), 1=WRITE (local->shm)
//  cmd_ptr        in   SIZE       shm start address (READ)
//  cmd_start      in   PROCSIZE   local start address
//  cmd_length     in   PROCSIZE   word count
//  done           out  1          1-cycle pulse on completion
//  busy           out  1          high ISSUE..DONE inclusive
//  err_timeout    out  1          sticky; cleared on next accepted command
//  result_ptr     out  SIZE-PAGE_SIZE  page index from DMA, captured at ack
//  trigger        out  1          toggled once per request
//  ack            in   1          DMA toggles once per completed request
//  action/ptr/copy_start/copy_length  out  1/SIZE/PROCSIZE/PROCSIZE  held stable while busy
//  ptr_out        in   SIZE-PAGE_SIZE  DMA returned page index
//  dma_mem_addr/dma_mem_rw/dma_mem_wdata  in  PROCSIZE/1/WORD_SIZE  DMA local-memory access
//  dma_mem_rdata  out  WORD_SIZE  = mem_rdata
//  core_mem_addr/core_mem_wren/core_mem_wdata  in  PROCSIZE/1/WORD_SIZE  core access
//  core_mem_rdata out  WORD_SIZE  = mem_rdata
//  core_mem_stall out  1          = busy
//  mem_addr/mem_wren/mem_wdata  out  PROCSIZE/1/WORD_SIZE  to local RAM
//  mem_rdata      in   WORD_SIZE  from local RAM
// BEHAVIOUR
//  Reset: state=IDLE, trigger=0, last_ack=0, done=0, busy=0, err_timeout=0, result_ptr=0,
//   action/ptr/copy_start/copy_length=0, timer=0. Reset mid-transfer aborts silently.
//  FSM IDLE->ISSUE->WAIT_ACK->DONE->IDLE.
//  IDLE: last_ack<=ack every cycle (stray/post-reset ack toggles ignored). On valid&ready:
//   latch cmd_* into action/ptr/copy_start/copy_length, clear err_timeout;
//   length==0 -> DONE directly (no trigger toggle); else -> ISSUE.
//  ISSUE: trigger<=~trigger, timer<=0, ->WAIT_ACK (trigger flips at edge after acceptance).
//  WAIT_ACK: if ack!=last_ack: last_ack<=ack, result_ptr<=ptr_out, ->DONE;
//   elif timer==TIMEOUT: err_timeout<=1, ->IDLE (no done pulse); else timer<=timer+1.
//   Ack toggle and timeout in same cycle: ack wins.
//  DONE: done=1 for this cycle only, ->IDLE. Ack detected at edge k -> done high cycle k+1.
//  Memory mux (combinational): busy -> mem_* = dma_mem_* (mem_wren=dma_mem_rw);
//   else mem_* = core_mem_*. Core writes during busy are dropped; core must honour stall.
//  cmd_ready=0 in ISSUE/WAIT_ACK/DONE; commands then are not accepted and not queued.
//  Latched outputs never change while busy, regardless of cmd_* activity.
// TESTING
//  1 WRITE len=3 start=2: accept@c0 -> trigger 0->1 @c1; ack toggle @c5 with ptr_out=2 -> done @c6, result_ptr=2.
//  2 READ ptr=5 len=4: DMA writes words via dma_mem_* -> mem_wren/addr follow DMA; core_mem_stall=1 throughout.
//  3 len=0 -> done 1 cycle after accept, trigger unchanged, busy 1 cycle.
//  4 TIMEOUT=8, no ack -> err_timeout=1 after 9 WAIT_ACK cycles, no done; next cmd clears it.
//  5 ack toggles in IDLE, then new cmd -> not mistaken for completion; waits for fresh toggle.
//  6 reset_n low in WAIT_ACK -> all outputs to reset values immediately; cmd_ready=1 after release.

Source files
------------

// File: rtl/dma_requester.sv
// dma_requester
//    Processor-side end of a toggle-handshake DMA request channel. The core
//    posts a copy command; the block latches it, flips trigger towards the DMA,
//    waits for the DMA to flip ack back, captures the returned page index and
//    pulses done. The local RAM port is handed to the DMA while busy.
//
// Ports
//    clock, reset_n                 system clock, async active-low reset
//    cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//    cmd_action/ptr/start/length    command fields
//    done, busy, err_timeout        status (done = 1-cycle pulse, err sticky)
//    result_ptr                     page index captured at ack
//    trigger, ack                   toggle handshake with the DMA
//    action/ptr/copy_start/copy_length  latched command towards the DMA
//    ptr_out                        page index returned by the DMA
//    dma_mem_*                      DMA access to local RAM
//    core_mem_*                     core access to local RAM (stalled while busy)
//    mem_*                          local RAM port
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a command, tracking ack so stray toggles are ignored
// ISSUE    | flip trigger, clear timeout timer
// WAIT_ACK | wait for ack toggle or timeout
// DONE     | one-cycle completion pulse
module dma_requester #(
   parameter int SIZE      = 4,
   parameter int PAGE_SIZE = 2,
   parameter int PROCSIZE  = 4,
   parameter int WORD_SIZE = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_action,
   input  logic [SIZE-1:0]           cmd_ptr,
   input  logic [PROCSIZE-1:0]       cmd_start,
   input  logic [PROCSIZE-1:0]       cmd_length,
   output logic                      done,
   output logic                      busy,
   output logic                      err_timeout,
   output logic [SIZE-PAGE_SIZE-1:0] result_ptr,
   output logic                      trigger,
   input  logic                      ack,
   output logic                      action,
   output logic [SIZE-1:0]           ptr,
   output logic [PROCSIZE-1:0]       copy_start,
   output logic [PROCSIZE-1:0]       copy_length,
   input  logic [SIZE-PAGE_SIZE-1:0] ptr_out,
   input  logic [PROCSIZE-1:0]       dma_mem_addr,
   input  logic                      dma_mem_rw,
   input  logic [WORD_SIZE-1:0]      dma_mem_wdata,
   output logic [WORD_SIZE-1:0]      dma_mem_rdata,
   input  logic [PROCSIZE-1:0]       core_mem_addr,
   input  logic                      core_mem_wren,
   input  logic [WORD_SIZE-1:0]      core_mem_wdata,
   output logic [WORD_SIZE-1:0]      core_mem_rdata,
   output logic                      core_mem_stall,
   output logic [PROCSIZE-1:0]       mem_addr,
   output logic                      mem_wren,
   output logic [WORD_SIZE-1:0]      mem_wdata,
   input  logic [WORD_SIZE-1:0]      mem_rdata
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_WAIT_ACK = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   logic [1:0]    state;
   logic          last_ack;
   logic [TW-1:0] timer;

   assign cmd_ready      = (state == S_IDLE);
   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign core_mem_stall = busy;
   assign dma_mem_rdata  = mem_rdata;
   assign core_mem_rdata = mem_rdata;

   // Core writes issued while busy never reach the RAM; the core is stalled.
   always_comb begin
      mem_addr  = core_mem_addr;
      mem_wren  = core_mem_wren;
      mem_wdata = core_mem_wdata;
      if (busy) begin
         mem_addr  = dma_mem_addr;
         mem_wren  = dma_mem_rw;
         mem_wdata = dma_mem_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         trigger     <= 1'b0;
         last_ack    <= 1'b0;
         err_timeout <= 1'b0;
         result_ptr  <= '0;
         action      <= 1'b0;
         ptr         <= '0;
         copy_start  <= '0;
         copy_length <= '0;
         timer       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Tracking ack here makes any toggle seen outside a request harmless.
               last_ack <= ack;
               if (cmd_valid && cmd_ready) begin
                  action      <= cmd_action;
                  ptr         <= cmd_ptr;
                  copy_start  <= cmd_start;
                  copy_length <= cmd_length;
                  err_timeout <= 1'b0;
                  state       <= (cmd_length == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               trigger <= ~trigger;
               timer   <= '0;
               state   <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               // An ack arriving on the timeout cycle still completes normally.
               if (ack != last_ack) begin
                  last_ack   <= ack;
                  result_ptr <= ptr_out;
                  state      <= S_DONE;
               end else if (timer == TIMEOUT_T) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_requester.sv
module tb_dma_requester;

   localparam int SIZE      = 4;
   localparam int PAGE_SIZE = 2;
   localparam int PROCSIZE  = 4;
   localparam int WORD_SIZE = 16;
   localparam int TIMEOUT   = 8;
   localparam int PW        = SIZE - PAGE_SIZE;

   logic                 clock;
   logic                 reset_n;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_action;
   logic [SIZE-1:0]      cmd_ptr;
   logic [PROCSIZE-1:0]  cmd_start;
   logic [PROCSIZE-1:0]  cmd_length;
   logic                 done;
   logic                 busy;
   logic                 err_timeout;
   logic [PW-1:0]        result_ptr;
   logic                 trigger;
   logic                 ack;
   logic                 action;
   logic [SIZE-1:0]      ptr;
   logic [PROCSIZE-1:0]  copy_start;
   logic [PROCSIZE-1:0]  copy_length;
   logic [PW-1:0]        ptr_out;
   logic [PROCSIZE-1:0]  dma_mem_addr;
   logic                 dma_mem_rw;
   logic [WORD_SIZE-1:0] dma_mem_wdata;
   logic [WORD_SIZE-1:0] dma_mem_rdata;
   logic [PROCSIZE-1:0]  core_mem_addr;
   logic                 core_mem_wren;
   logic [WORD_SIZE-1:0] core_mem_wdata;
   logic [WORD_SIZE-1:0] core_mem_rdata;
   logic                 core_mem_stall;
   logic [PROCSIZE-1:0]  mem_addr;
   logic                 mem_wren;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;

   dma_requester #(
      .SIZE(SIZE), .PAGE_SIZE(PAGE_SIZE), .PROCSIZE(PROCSIZE),
      .WORD_SIZE(WORD_SIZE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_action(cmd_action),
      .cmd_ptr(cmd_ptr), .cmd_start(cmd_start), .cmd_length(cmd_length),
      .done(done), .busy(busy), .err_timeout(err_timeout), .result_ptr(result_ptr),
      .trigger(trigger), .ack(ack), .action(action), .ptr(ptr),
      .copy_start(copy_start), .copy_length(copy_length), .ptr_out(ptr_out),
      .dma_mem_addr(dma_mem_addr), .dma_mem_rw(dma_mem_rw),
      .dma_mem_wdata(dma_mem_wdata), .dma_mem_rdata(dma_mem_rdata),
      .core_mem_addr(core_mem_addr), .core_mem_wren(core_mem_wren),
      .core_mem_wdata(core_mem_wdata), .core_mem_rdata(core_mem_rdata),
      .core_mem_stall(core_mem_stall),
      .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic          timeout;
      logic [PW-1:0] rptr;
   } exp_t;

   exp_t exp_q[$];
   logic exp_trig;
   int   cyc;
   logic trig_saved;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents one command for a single edge; the DUT is expected to be in IDLE.
   task automatic send(input logic act, input logic [SIZE-1:0] p,
                       input logic [PROCSIZE-1:0] st, input logic [PROCSIZE-1:0] ln);
      cmd_valid  = 1'b1;
      cmd_action = act;
      cmd_ptr    = p;
      cmd_start  = st;
      cmd_length = ln;
      tick();
      cmd_valid  = 1'b0;
   endtask

   // Waits (bounded) for done or a timeout flag, then checks it against the scoreboard.
   task automatic wait_outcome(input int max_cyc, output int ncyc);
      exp_t e;
      bit   found;
      found = 1'b0;
      ncyc  = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (done || err_timeout) begin
            found = 1'b1;
            ncyc  = i;
            break;
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $error("FAIL outcome_wait: observed no done/timeout, required one within %0d cycles", max_cyc);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL outcome_unexpected: observed done=%0b err=%0b, required no outcome", done, err_timeout);
      end else begin
         e = exp_q.pop_front();
         check("outcome_err", err_timeout, e.timeout);
         check("outcome_done", done, !e.timeout);
         if (!e.timeout) check("result_ptr", result_ptr, e.rptr);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      cmd_valid      = 1'b0;
      cmd_action     = 1'b0;
      cmd_ptr        = '0;
      cmd_start      = '0;
      cmd_length     = '0;
      ack            = 1'b0;
      ptr_out        = '0;
      dma_mem_addr   = '0;
      dma_mem_rw     = 1'b0;
      dma_mem_wdata  = '0;
      core_mem_addr  = '0;
      core_mem_wren  = 1'b0;
      core_mem_wdata = '0;
      mem_rdata      = '0;
      exp_trig       = 1'b0;

      // Reset state
      #2;
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_trigger", trigger, 0);
      check("rst_err", err_timeout, 0);
      check("rst_result_ptr", result_ptr, 0);
      check("rst_copy_length", copy_length, 0);
      #10 reset_n = 1'b1;
      tick();

      // 1: WRITE len=3 start=2, ack toggled four edges after trigger
      send(1'b1, 4'd9, 4'd2, 4'd3);
      check("t1_busy_issue", busy, 1);
      check("t1_ready_issue", cmd_ready, 0);
      check("t1_trigger_c0", trigger, exp_trig);
      check("t1_action", action, 1);
      check("t1_copy_start", copy_start, 2);
      check("t1_copy_length", copy_length, 3);
      tick();
      exp_trig = ~exp_trig;
      check("t1_trigger_c1", trigger, exp_trig);
      // Scramble the command bus while busy: latched fields must hold.
      cmd_valid  = 1'b1;
      cmd_action = 1'b0;
      cmd_start  = 4'd7;
      cmd_length = 4'd9;
      tick();
      tick();
      tick();
      check("t1_hold_action", action, 1);
      check("t1_hold_start", copy_start, 2);
      check("t1_hold_length", copy_length, 3);
      check("t1_no_done", done, 0);
      cmd_valid = 1'b0;
      ack       = ~ack;
      ptr_out   = 2'd2;
      exp_q.push_back('{timeout: 1'b0, rptr: 2'd2});
      wait_outcome(20, cyc);
      check("t1_done_latency", cyc, 1);
      tick();
      check("t1_done_pulse", done, 0);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_ready", cmd_ready, 1);

      // 2: READ ptr=5 len=4, DMA owns the RAM port while busy
      core_mem_addr  = 4'hF;
      core_mem_wren  = 1'b1;
      core_mem_wdata = 16'hBEEF;
      send(1'b0, 4'd5, 4'd1, 4'd4);
      check("t2_action", action, 0);
      check("t2_ptr", ptr, 5);
      tick();
      exp_trig = ~exp_trig;
      check("t2_trigger", trigger, exp_trig);
      for (int k = 0; k < 4; k++) begin
         dma_mem_addr  = 4'(1 + k);
         dma_mem_rw    = 1'b1;
         dma_mem_wdata = 16'h1000 + 16'(k);
         mem_rdata     = 16'h5A00 + 16'(k);
         #1;
         check("t2_mem_addr", mem_addr, 4'(1 + k));
         check("t2_mem_wren", mem_wren, 1);
         check("t2_mem_wdata", mem_wdata, 16'h1000 + 16'(k));
         check("t2_stall", core_mem_stall, 1);
         check("t2_core_rdata", core_mem_rdata, 16'h5A00 + 16'(k));
         check("t2_dma_rdata", dma_mem_rdata, 16'h5A00 + 16'(k));
         tick();
      end
      dma_mem_rw = 1'b0;
      ack        = ~ack;
      ptr_out    = 2'd1;
      exp_q.push_back('{timeout: 1'b0, rptr: 2'd1});
      wait_outcome(20, cyc);
      check("t2_done_latency", cyc, 1);
      tick();
      check("t2_core_addr", mem_addr, 4'hF);
      check("t2_core_wren", mem_wren, 1);
      check("t2_core_wdata", mem_wdata, 16'hBEEF);
      check("t2_stall_idle", core_mem_stall, 0);
      core_mem_wren = 1'b0;

      // 3: zero length completes without a trigger toggle
      trig_saved = trigger;
      send(1'b1, 4'd3, 4'd4, 4'd0);
      check("t3_done", done, 1);
      check("t3_busy", busy, 1);
      check("t3_trigger", trigger, exp_trig);
      tick();
      check("t3_done_off", done, 0);
      check("t3_busy_off", busy, 0);
      check("t3_trigger_hold", trigger, trig_saved);

      // 4: no ack -> timeout after TIMEOUT+1 WAIT_ACK cycles, no done
      send(1'b1, 4'd0, 4'd0, 4'd1);
      tick();
      exp_trig = ~exp_trig;
      check("t4_trigger", trigger, exp_trig);
      exp_q.push_back('{timeout: 1'b1, rptr: 2'd0});
      wait_outcome(30, cyc);
      check("t4_timeout_cycles", cyc, TIMEOUT + 1);
      check("t4_busy", busy, 0);
      tick();
      check("t4_err_sticky", err_timeout, 1);
      check("t4_no_done", done, 0);

      // 5: stray ack toggle in IDLE must not complete the next request
      ack     = ~ack;
      ptr_out = 2'd0;
      tick();
      tick();
      send(1'b0, 4'd6, 4'd3, 4'd2);
      check("t5_err_cleared", err_timeout, 0);
      tick();
      exp_trig = ~exp_trig;
      check("t5_trigger", trigger, exp_trig);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t5_no_done", done, 0);
         check("t5_still_busy", busy, 1);
      end
      ack     = ~ack;
      ptr_out = 2'd3;
      exp_q.push_back('{timeout: 1'b0, rptr: 2'd3});
      wait_outcome(20, cyc);
      check("t5_done_latency", cyc, 1);
      tick();

      // 6: reset in WAIT_ACK clears everything immediately
      send(1'b1, 4'd8, 4'd5, 4'd5);
      tick();
      tick();
      check("t6_busy_wait", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      exp_trig = 1'b0;
      check("t6_trigger", trigger, exp_trig);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_result_ptr", result_ptr, 0);
      check("t6_action", action, 0);
      check("t6_ptr", ptr, 0);
      check("t6_copy_start", copy_start, 0);
      check("t6_copy_length", copy_length, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      check("t6_ready", cmd_ready, 1);
      check("t6_busy_after", busy, 0);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
